// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for the Harris corner detector: feeds one WxH frame with
// inter-line gaps, drains the pipeline, and tallies corners per frame.
module harris_frame_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 464,
  parameter int unsigned LINE_GAP     = 4,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_pixel,
  output logic                   in_ready,
  output logic                   det_valid,
  output logic [DATA_WIDTH-1:0]  det_pixel,
  input  logic                   det_out_valid,
  input  logic                   det_corner,
  output logic                   busy,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] corner_count,
  output logic [15:0]            frame_count
);

  localparam int unsigned X_W       = $clog2(IMAGE_WIDTH);
  localparam int unsigned Y_W       = $clog2(IMAGE_HEIGHT);
  localparam int unsigned G_W       = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int unsigned D_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned GAP_LAST  = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;
  localparam bit          HAS_GAP   = (LINE_GAP > 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [G_W-1:0]         gap_q;
  logic [D_W-1:0]         drain_q;
  logic [COUNT_WIDTH-1:0] live_q;
  logic [COUNT_WIDTH-1:0] live_inc;
  logic                   accept;
  logic                   x_last;
  logic                   y_last;
  logic                   gap_last;
  logic                   drain_last;
  logic                   corner_hit;

  // Status and handshake decode straight from state so reset clears them at once
  assign in_ready   = (state_q == FEED);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  assign accept     = in_ready & in_valid;
  assign x_last     = (x_q == X_W'(IMAGE_WIDTH - 1));
  assign y_last     = (y_q == Y_W'(IMAGE_HEIGHT - 1));
  assign gap_last   = (gap_q == G_W'(GAP_LAST));
  assign drain_last = (drain_q == D_W'(DRAIN_CYCLES - 1));
  assign corner_hit = busy & det_out_valid & det_corner;

  // Saturating live corner total including this cycle's hit
  assign live_inc = (corner_hit && (live_q != '1)) ? live_q + COUNT_WIDTH'(1) : live_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = FEED;
      end
      FEED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && x_last) begin
          if (y_last)       state_d = DRAIN;
          else if (HAS_GAP) state_d = GAP;
          else              state_d = FEED;
        end
      end
      GAP: begin
        if (abort)         state_d = IDLE;
        else if (gap_last) state_d = FEED;
      end
      DRAIN: begin
        if (abort)           state_d = IDLE;
        else if (drain_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: pixel register, position/gap/drain counters, corner totals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_valid    <= 1'b0;
      det_pixel    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      gap_q        <= '0;
      drain_q      <= '0;
      live_q       <= '0;
      corner_count <= '0;
      frame_count  <= '0;
    end else begin
      det_valid <= accept & ~abort;
      if (accept && !abort) det_pixel <= in_pixel;
      if (busy) live_q <= live_inc;

      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            x_q    <= '0;
            y_q    <= '0;
            live_q <= '0;
          end
        end
        FEED: begin
          gap_q   <= '0;
          drain_q <= '0;
          if (accept && !abort) begin
            if (x_last) begin
              x_q <= '0;
              if (!y_last) y_q <= y_q + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end
        GAP: begin
          gap_q <= gap_q + G_W'(1);
        end
        DRAIN: begin
          drain_q <= drain_q + D_W'(1);
        end
        DONE: begin
          if (!abort) begin
            corner_count <= live_inc;
            frame_count  <= frame_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Self-checking bench for harris_frame_ctrl: a frame-level model (accepted
// pixel count plus idle countdown) predicts every output each cycle.
module tb_harris_frame_ctrl;

  localparam int unsigned DW   = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned LG   = 2;
  localparam int unsigned DC   = 5;
  localparam int unsigned CW   = 16;
  localparam int          NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [DW-1:0] in_pixel;
  logic          in_ready;
  logic          det_valid;
  logic [DW-1:0] det_pixel;
  logic          det_out_valid;
  logic          det_corner;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] corner_count;
  logic [15:0]   frame_count;

  int checks   = 0;
  int failures = 0;

  // Model: frame progress as pixels accepted and idle cycles still owed
  bit            m_busy;
  bit            m_done;
  bit            m_dv;
  logic [DW-1:0] m_dp;
  int            m_k;
  int            m_wait;
  int            m_live;
  int            m_cc;
  int            m_fc;
  int            src_pix;

  always #5 clk = ~clk;

  harris_frame_ctrl #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .LINE_GAP    (LG),
    .DRAIN_CYCLES(DC),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_pixel     (in_pixel),
    .in_ready     (in_ready),
    .det_valid    (det_valid),
    .det_pixel    (det_pixel),
    .det_out_valid(det_out_valid),
    .det_corner   (det_corner),
    .busy         (busy),
    .frame_done   (frame_done),
    .corner_count (corner_count),
    .frame_count  (frame_count)
  );

  function automatic bit m_ready();
    return m_busy && !m_done && (m_wait == 0) && (m_k < NPIX);
  endfunction

  function automatic logic [44:0] m_vec();
    return {m_busy, m_ready(), m_done, m_dv, m_dp, 16'(m_cc), 16'(m_fc)};
  endfunction

  function automatic logic [44:0] d_vec();
    return {busy, in_ready, frame_done, det_valid, det_pixel, corner_count, frame_count};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_dv = 0; m_dp = '0;
    m_k = 0; m_wait = 0; m_live = 0; m_cc = 0; m_fc = 0; src_pix = 0;
  endtask

  // Drive one cycle of inputs, advance the model, land on the next negedge
  task automatic step(input bit s, input bit a, input bit v, input bit dov, input bit dc);
    bit acc;
    start = s; abort = a; in_valid = v;
    in_pixel = v ? DW'(src_pix) : DW'($urandom);
    det_out_valid = dov; det_corner = dc;
    acc = m_ready() && v;
    if (m_busy && dov && dc && m_live < 65535) m_live++;
    m_dv = acc && !a;
    if (m_dv) m_dp = in_pixel;
    if (acc) src_pix++;
    if (m_busy && a) begin
      m_busy = 0; m_done = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (s && !a) begin
        m_busy = 1; m_k = 0; m_wait = 0; m_done = 0; m_live = 0; src_pix = 0;
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0; m_cc = m_live; m_fc = (m_fc + 1) % 65536;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0 && m_k == NPIX) m_done = 1;
    end else if (acc) begin
      m_k++;
      if (m_k == NPIX)         m_wait = DC;
      else if (m_k % W == 0)   m_wait = LG;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_vec() !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", d_vec());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (d_vec() !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", d_vec());
    end
    step(0, 0, 1, 1, 1);
    checks++;
    if (d_vec() !== m_vec()) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", d_vec(), m_vec());
    end
  endtask

  task automatic test_basic();
    int nb = 0, ndone = 0, first_dv = -1, last_dv = 0, done_cyc = 0;
    logic [15:0] pat = '0;
    step(1, 0, 0, 0, 0);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL basic_start busy/rdy=%b want=11", {busy, in_ready});
    end
    for (int c = 0; c < 100 && m_busy; c++) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL basic_cycle c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
      if (det_valid) begin
        if (first_dv < 0) first_dv = c;
        checks++;
        if (det_pixel !== DW'(nb)) begin
          failures++;
          $display("FAIL basic_pixel beat=%0d got=%0d want=%0d", nb, det_pixel, nb);
        end
        nb++;
        last_dv = c;
      end
      if (first_dv >= 0 && c - first_dv < 16) pat[15 - (c - first_dv)] = det_valid;
      if (frame_done) begin ndone++; done_cyc = c; end
    end
    checks++;
    if (m_busy) begin failures++; $display("FAIL basic_timeout busy=%b want=0", busy); end
    checks++;
    if (pat !== 16'b1111_0011_1100_1111) begin
      failures++;
      $display("FAIL basic_pattern got=%b want=1111001111001111", pat);
    end
    checks++;
    if (nb != NPIX || ndone != 1) begin
      failures++;
      $display("FAIL basic_counts beats=%0d dones=%0d want=%0d/1", nb, ndone, NPIX);
    end
    checks++;
    if (done_cyc - last_dv != DC) begin
      failures++;
      $display("FAIL basic_done_latency got=%0d want=%0d", done_cyc - last_dv, DC);
    end
    checks++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end frame_count=%0d busy=%b want=1/0", frame_count, busy);
    end
  endtask

  task automatic test_stalls();
    int nb = 0, ndone = 0;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 200 && m_busy; c++) begin
      step(0, 0, c[0] == 1'b0, 0, 0);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL stall_cycle c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
      if (det_valid) begin
        checks++;
        if (det_pixel !== DW'(nb)) begin
          failures++;
          $display("FAIL stall_pixel beat=%0d got=%0d want=%0d", nb, det_pixel, nb);
        end
        nb++;
      end
      if (frame_done) ndone++;
    end
    checks++;
    if (nb != NPIX || ndone != 1 || m_busy) begin
      failures++;
      $display("FAIL stall_counts beats=%0d dones=%0d want=%0d/1", nb, ndone, NPIX);
    end
  endtask

  task automatic test_corners();
    bit dc;
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 100 && m_busy; c++) begin
      dc = (c == 1) || (c == 6) || (c == 17) || m_done;
      step(0, 0, 1, dc, dc);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL corner_cycle c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
    end
    checks++;
    if (corner_count !== 16'd4) begin
      failures++;
      $display("FAIL corner_total got=%0d want=4", corner_count);
    end
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 100 && m_busy; c++) begin
      step(0, 0, 1, 1'b1, 1'b0);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL corner2_cycle c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
    end
    checks++;
    if (corner_count !== 16'd0) begin
      failures++;
      $display("FAIL corner_restart got=%0d want=0", corner_count);
    end
  endtask

  task automatic test_abort();
    int cc0 = m_cc, fc0 = m_fc, nb = 0, ndone = 0;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 50 && m_k < 6; c++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    checks++;
    if ({busy, in_ready, det_valid, frame_done} !== 4'b0000 ||
        corner_count !== 16'(cc0) || frame_count !== 16'(fc0)) begin
      failures++;
      $display("FAIL abort_state got=%b cc=%0d fc=%0d want=0000 cc=%0d fc=%0d",
               {busy, in_ready, det_valid, frame_done}, corner_count, frame_count, cc0, fc0);
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle c=%0d done=%b busy=%b want=0/0", c, frame_done, busy);
      end
    end
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 100 && m_busy; c++) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL abort_refeed c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
      if (det_valid) begin
        checks++;
        if (det_pixel !== DW'(nb)) begin
          failures++;
          $display("FAIL abort_pixel beat=%0d got=%0d want=%0d", nb, det_pixel, nb);
        end
        nb++;
      end
      if (frame_done) ndone++;
    end
    checks++;
    if (nb != NPIX || ndone != 1 || frame_count !== 16'(fc0 + 1)) begin
      failures++;
      $display("FAIL abort_refeed_counts beats=%0d dones=%0d fc=%0d want=%0d/1/%0d",
               nb, ndone, frame_count, NPIX, fc0 + 1);
    end
  endtask

  task automatic test_start_ignored();
    int fc0 = m_fc, ndone = 0;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 100 && m_busy; c++) begin
      step($urandom_range(0, 2) == 0, 0, 1, 0, 0);
      checks++;
      if (d_vec() !== m_vec()) begin
        failures++;
        $display("FAIL busy_start c=%0d got=%h want=%h", c, d_vec(), m_vec());
      end
      if (frame_done) ndone++;
    end
    for (int c = 0; c < 4; c++) begin
      step(1, 1, 1, 0, 0);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL start_abort_idle c=%0d busy=%b want=0", c, busy);
      end
    end
    checks++;
    if (ndone != 1 || frame_count !== 16'(fc0 + 1)) begin
      failures++;
      $display("FAIL start_ignored dones=%0d fc=%0d want=1/%0d", ndone, frame_count, fc0 + 1);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      step(1, 0, 0, 0, 0);
      for (int c = 0; c < 300 && m_busy; c++) begin
        step(0, (f == 1) && ($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
             1'($urandom), 1'($urandom));
        checks++;
        if (d_vec() !== m_vec()) begin
          failures++;
          $display("FAIL random f=%0d c=%0d got=%h want=%h", f, c, d_vec(), m_vec());
        end
      end
      step(0, 0, 0, 1, 1);
      checks++;
      if (m_busy || corner_count !== 16'(m_cc) || frame_count !== 16'(m_fc)) begin
        failures++;
        $display("FAIL random_end f=%0d cc=%0d fc=%0d want=%0d/%0d",
                 f, corner_count, frame_count, m_cc, m_fc);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 100 && m_k < NPIX; c++) step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    checks++;
    if (!(m_busy && m_wait > 0) || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_drain busy=%b rdy=%b want=1/0", busy, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (d_vec() !== '0) begin
      failures++;
      $display("FAIL areset_immediate got=%h want=0", d_vec());
    end
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_vec() !== '0) begin
      failures++;
      $display("FAIL areset_release got=%h want=0", d_vec());
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_pixel = '0;
    det_out_valid = 1'b0; det_corner = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_stalls();
    test_corners();
    test_abort();
    test_start_ignored();
    test_random();
    test_async_reset();
    test_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
